// File: rtl/exec_muldiv_if.sv
// Request/response bundle between the execution stage and the multiply/divide unit.
// The stage drives the master side; the unit implements the slave side.
interface exec_muldiv_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_adr_i;
    logic            kill_i;
    logic            done_o;
    logic [XLEN-1:0] res_o;
    logic [4:0]      rd_adr_o;

    modport master (
        output req_i, funct3_i, rs1_i, rs2_i, rd_adr_i, kill_i,
        input  ready_o, done_o, res_o, rd_adr_o
    );

    modport slave (
        input  req_i, funct3_i, rs1_i, rs2_i, rd_adr_i, kill_i,
        output ready_o, done_o, res_o, rd_adr_o
    );
endinterface

// File: rtl/exec_muldiv.sv
// Multi-cycle RV32M multiply/divide unit for the execution stage.
// Multiplies complete after MUL_LAT edges; divides use a radix-2^DIV_BITS restoring loop.
module exec_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_BITS = 1
) (
    input logic          clk,
    input logic          rst_n,
    exec_muldiv_if.slave bus
);
    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int CNT_W     = $clog2(DIV_ITERS) + 1;
    localparam int MUL_LAST  = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic [XLEN-1:0]  opA_q, opB_q;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  quo_q;
    logic             negQ_q, negR_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  res_q;
    logic [4:0]       rdOut_q;
    logic             done_q;

    logic                    idle, accept;
    logic [2:0]              mf3;
    logic [XLEN-1:0]         ma, mb;
    logic signed [XLEN:0]    mulA, mulB;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]         mulRes;
    logic                    divSgn, divZero, divOvf, special;
    logic [XLEN-1:0]         specialRes, absA, absB;
    logic [XLEN:0]           remIn, remN;
    logic [XLEN-1:0]         quoIn, quoN, dvsIn;
    logic [XLEN-1:0]         qFix, rFix, fixRes;

    assign idle   = (state_q == IDLE);
    assign accept = bus.req_i & idle & ~bus.kill_i;

    // Multiplier sees live inputs in IDLE (MUL_LAT=1 path) and latched operands otherwise.
    always_comb begin
        mf3    = idle ? bus.funct3_i : f3_q;
        ma     = idle ? bus.rs1_i : opA_q;
        mb     = idle ? bus.rs2_i : opB_q;
        mulA   = $signed({(mf3[1:0] != 2'b11) & ma[XLEN-1], ma});
        mulB   = $signed({~mf3[1] & mb[XLEN-1], mb});
        prod   = mulA * mulB;
        mulRes = (mf3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        divSgn  = ~bus.funct3_i[0];
        divZero = (bus.rs2_i == '0);
        divOvf  = divSgn && (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_i == '1);
        special = bus.funct3_i[2] & (divZero | divOvf);
        if (divZero)
            specialRes = bus.funct3_i[1] ? bus.rs1_i : '1;
        else
            specialRes = bus.funct3_i[1] ? '0 : bus.rs1_i;
        absA = (divSgn & bus.rs1_i[XLEN-1]) ? -bus.rs1_i : bus.rs1_i;
        absB = (divSgn & bus.rs2_i[XLEN-1]) ? -bus.rs2_i : bus.rs2_i;
    end

    // The accepting edge already resolves the first quotient digit from the live operands.
    always_comb begin
        remIn = idle ? '0 : rem_q;
        quoIn = idle ? absA : quo_q;
        dvsIn = idle ? absB : opB_q;
        remN  = remIn;
        quoN  = quoIn;
        for (int i = 0; i < DIV_BITS; i++) begin
            remN = {remN[XLEN-1:0], quoN[XLEN-1]};
            quoN = {quoN[XLEN-2:0], 1'b0};
            if (remN >= {1'b0, dvsIn}) begin
                remN    = remN - {1'b0, dvsIn};
                quoN[0] = 1'b1;
            end
        end
        qFix   = negQ_q ? -quo_q : quo_q;
        rFix   = negR_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        fixRes = f3_q[1] ? rFix : qFix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            rdOut_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        f3_q <= bus.funct3_i;
                        rd_q <= bus.rd_adr_i;
                        if (!bus.funct3_i[2]) begin
                            if (MUL_LAT == 1) begin
                                res_q   <= mulRes;
                                rdOut_q <= bus.rd_adr_i;
                                done_q  <= 1'b1;
                            end else begin
                                opA_q   <= bus.rs1_i;
                                opB_q   <= bus.rs2_i;
                                cnt_q   <= '0;
                                state_q <= MUL;
                            end
                        end else if (special) begin
                            res_q   <= specialRes;
                            rdOut_q <= bus.rd_adr_i;
                            done_q  <= 1'b1;
                        end else begin
                            rem_q   <= remN;
                            quo_q   <= quoN;
                            opB_q   <= absB;
                            negQ_q  <= divSgn & (bus.rs1_i[XLEN-1] ^ bus.rs2_i[XLEN-1]);
                            negR_q  <= divSgn & bus.rs1_i[XLEN-1];
                            cnt_q   <= CNT_W'(1);
                            state_q <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (bus.kill_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(MUL_LAST)) begin
                        res_q   <= mulRes;
                        rdOut_q <= rd_q;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (bus.kill_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= remN;
                        quo_q <= quoN;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DIV_ITERS - 1))
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!bus.kill_i) begin
                        res_q   <= fixRes;
                        rdOut_q <= rd_q;
                        done_q  <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o  = idle;
    assign bus.done_o   = done_q;
    assign bus.res_o    = res_q;
    assign bus.rd_adr_o = rdOut_q;
endmodule

// File: tb/tb_exec_muldiv.sv
// Scoreboard bench for exec_muldiv: directed vectors on the default unit plus
// reference-model checks on two extra parameterisations (MUL_LAT 4/1, DIV_BITS 2).
module tb_exec_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;
    exp_t sbQ[$];

    exec_muldiv_if #(.XLEN(32)) bus ();
    exec_muldiv_if #(.XLEN(32)) b2 ();
    exec_muldiv_if #(.XLEN(32)) b3 ();

    exec_muldiv #(.XLEN(32), .MUL_LAT(2), .DIV_BITS(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    exec_muldiv #(.XLEN(32), .MUL_LAT(4), .DIV_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    exec_muldiv #(.XLEN(32), .MUL_LAT(1), .DIV_BITS(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pops one expectation per done pulse; a pulse with nothing queued is itself an error.
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("res_o", bus.res_o, e.res);
                checkOutput("rd_adr_o", {27'd0, bus.rd_adr_o}, {27'd0, e.rd});
                checkOutput("latency_cycle", 32'(cycle), 32'(e.due));
            end
        end
    end

    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
            3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic waitReady();
        int n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready_o) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    // Called at a falling edge; issues one request and returns on the next falling edge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expRes, input int lat,
                                 input bit expectDone);
        exp_t e;
        waitReady();
        bus.req_i    = 1'b1;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.rd_adr_i = rd;
        if (expectDone) begin
            e.res = expRes;
            e.rd  = rd;
            e.due = cycle + lat;
            sbQ.push_back(e);
        end
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
        @(negedge clk);
    endtask

    // Drives both extra units with one operation and measures each latency in falling edges.
    task automatic runSweep(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat2 = 0, lat3 = 0, exp2, exp3;
        logic [31:0] res2 = '0, res3 = '0, expRes;
        logic spec;
        expRes = refModel(f3, a, b);
        spec = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp2 = f3[2] ? (spec ? 1 : 17) : 4;
        exp3 = f3[2] ? (spec ? 1 : 17) : 1;
        b2.req_i = 1'b1; b2.funct3_i = f3; b2.rs1_i = a; b2.rs2_i = b;
        b3.req_i = 1'b1; b3.funct3_i = f3; b3.rs1_i = a; b3.rs2_i = b;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            b2.req_i = 1'b0;
            b3.req_i = 1'b0;
            if (b2.done_o && lat2 == 0) begin lat2 = k; res2 = b2.res_o; end
            if (b3.done_o && lat3 == 0) begin lat3 = k; res3 = b3.res_o; end
        end
        checkOutput("sweep_res_lat4_r4", res2, expRes);
        checkOutput("sweep_lat_lat4_r4", 32'(lat2), 32'(exp2));
        checkOutput("sweep_res_lat1_r4", res3, expRes);
        checkOutput("sweep_lat_lat1_r4", 32'(lat3), 32'(exp3));
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        bus.req_i = 1'b0; bus.kill_i = 1'b0; bus.funct3_i = '0;
        bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_adr_i = '0;
        b2.req_i = 1'b0; b2.kill_i = 1'b0; b2.funct3_i = '0;
        b2.rs1_i = '0; b2.rs2_i = '0; b2.rd_adr_i = '0;
        b3.req_i = 1'b0; b3.kill_i = 1'b0; b3.funct3_i = '0;
        b3.rs1_i = '0; b3.rs2_i = '0; b3.rd_adr_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("reset_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("reset_res", bus.res_o, 32'd0);
        checkOutput("reset_rd", {27'd0, bus.rd_adr_o}, 32'd0);

        // Multiplies, latency 2
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 2, 1'b1);
        checkOutput("mul_ready_low", {31'd0, bus.ready_o}, 32'd0);
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 1'b1);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 2, 1'b1);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2, 1'b1);
        applyStimulus(3'b000, 32'd3, 32'd5, 5'd7, 32'd15, 2, 1'b1);

        // Divides, latency 33
        applyStimulus(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33, 1'b1);
        checkOutput("div_ready_low", {31'd0, bus.ready_o}, 32'd0);
        applyStimulus(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'h0000_0001, 33, 1'b1);
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 33, 1'b1);
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 33, 1'b1);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 33, 1'b1);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 33, 1'b1);
        drain();

        // Special divides complete on the accepting edge and never drop ready
        applyStimulus(3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 1'b1);
        checkOutput("special_ready_high", {31'd0, bus.ready_o}, 32'd1);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1'b1);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1, 1'b1);
        applyStimulus(3'b110, 32'hFFFF_FFFD, 32'd0, 5'd17, 32'hFFFF_FFFD, 1, 1'b1);
        applyStimulus(3'b111, 32'd5, 32'd0, 5'd18, 32'd5, 1, 1'b1);
        checkOutput("special_ready_high2", {31'd0, bus.ready_o}, 32'd1);
        drain();

        // Kill mid-divide: no done, result register untouched
        applyStimulus(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd19, 32'd0, 33, 1'b0);
        repeat (4) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        checkOutput("kill_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("kill_res_held", bus.res_o, 32'd5);
        repeat (40) @(negedge clk);

        // Request together with kill is not accepted
        bus.req_i = 1'b1; bus.kill_i = 1'b1;
        bus.funct3_i = 3'b101; bus.rs1_i = 32'd100; bus.rs2_i = 32'd7; bus.rd_adr_i = 5'd20;
        @(negedge clk);
        bus.req_i = 1'b0; bus.kill_i = 1'b0;
        checkOutput("req_kill_no_accept", {31'd0, bus.ready_o}, 32'd1);
        repeat (40) @(negedge clk);

        // Back-to-back: multiply issued in the divide's done cycle
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33, 1'b1);
        n = 0;
        while (!bus.done_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        applyStimulus(3'b000, 32'd6, 32'd7, 5'd6, 32'd42, 2, 1'b1);
        drain();

        // Reset pulsed mid-divide
        applyStimulus(3'b101, 32'd1000, 32'd3, 5'd21, 32'd0, 33, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("midrst_done", {31'd0, bus.done_o}, 32'd0);
        checkOutput("midrst_res", bus.res_o, 32'd0);
        checkOutput("midrst_rd", {27'd0, bus.rd_adr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Other parameterisations against the reference model
        runSweep(3'b110, 32'hFFFF_FFF9, 32'd2);
        runSweep(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            runSweep(3'($urandom_range(0, 7)), a, b);
        end

        drain();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
